result_buffer: RTL

Downstream consumer of the 8-bit add pipeline: captures each 9-bit sum (8-bit sum plus carry) it produces into a small in-order FIFO and hands results to the writeback side over a valid/ready handshake. It decouples the fixed-latency adder from a stalling consumer and obeys the same `flush` used by the adder, so a pipeline flush discards every buffered result in one cycle.

---
 rtl/result_buffer.sv | 94 +++++++++
 1 files changed

// File: rtl/result_buffer.sv
// rtl/result_buffer.sv - in-order result FIFO between the adder pipeline and writeback; optional zero-latency path under RESULT_BUFFER_BYPASS_EN
module result_buffer #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_result,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_result,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Ready depends only on occupancy, so a pop at full does not admit a push until the next cycle.
    assign in_ready = !full;
    // Only stored entries are ever popped from the array; a bypassed result never touches it.
    assign pop      = !empty && out_ready;

`ifdef RESULT_BUFFER_BYPASS_EN
    logic bypass;
    assign bypass = empty && !flush;

    // When empty, the incoming result is offered straight to the consumer and stored only if refused.
    always_comb begin
        out_valid  = !empty || (bypass && in_valid);
        out_result = '0;
        if (!empty) begin
            out_result = mem[rd_ptr];
        end else if (bypass && in_valid) begin
            out_result = in_result;
        end
        push = in_valid && in_ready && !(bypass && out_ready);
    end
`else
    // Outputs come from registered state only; the head entry is visible one edge after its push.
    always_comb begin
        out_valid  = !empty;
        out_result = empty ? '0 : mem[rd_ptr];
        push       = in_valid && in_ready;
    end
`endif

    // Pointer and occupancy update; reset beats flush, flush beats any push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Result storage; contents are left untouched by reset and flush since the pointers hide them.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= in_result;
        end
    end

endmodule
